// File: rtl/ram_be_pipe.sv
// Single-port data memory for the load/store path: byte-enable writes,
// fixed-latency registered read pipeline, fall-through response FIFO and
// credit-based request flow control so no response is ever dropped.

// One byte lane of the memory array; the word is split across NB lanes.
module ram_be_pipe_lane #(
  parameter int DEPTH = 4096,
  parameter int IW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  // Byte write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];
endmodule

module ram_be_pipe #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4096,
  parameter int ADDR_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int ALIGN_CHK = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_be_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o
);
  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);
  localparam int FD  = RD_LAT + 1;       // FIFO depth == credit limit
  localparam int CW  = $clog2(FD + 1);
  localparam int PW  = $clog2(FD);

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic                  acc, cons, up;
  logic [CW-1:0]         credit;
  logic [IW-1:0]         idx;
  logic                  oor, mis, err;
  logic [NB-1:0][7:0]    rd_word;
  rsp_t                  s_in, p_dat, head;
  logic                  p_vld;
  logic [RD_LAT-1:0]     vld_pipe;
  rsp_t [RD_LAT-1:0]     dat_pipe;
  rsp_t                  fifo_mem [FD];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         f_cnt;
  logic                  f_empty, push, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
  endfunction

  assign acc  = req_valid_i && req_ready_o;
  assign cons = rsp_valid_o && rsp_ready_i;

  // Address decode: word index, out-of-range and misalignment.
  assign idx = req_addr_i[OFF +: IW];
  generate
    if (ADDR_W > OFF + IW) begin : g_oor
      assign oor = |req_addr_i[ADDR_W-1:OFF+IW];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
    if (OFF > 0) begin : g_mis
      assign mis = (ALIGN_CHK != 0) && (|req_addr_i[OFF-1:0]);
    end else begin : g_no_mis
      assign mis = 1'b0;
    end
  endgenerate
  assign err = oor || mis;

  generate
    for (genvar b = 0; b < NB; b++) begin : g_lane
      ram_be_pipe_lane #(.DEPTH(DEPTH), .IW(IW)) u_lane (
        .clk   (clk),
        .we    (acc && req_we_i && !err && req_be_i[b]),
        .idx   (idx),
        .wdata (req_wdata_i[8*b +: 8]),
        .rdata (rd_word[b])
      );
    end
  endgenerate

  // Response payload formed at acceptance; writes and errors return zero data.
  always_comb begin
    s_in.err  = err;
    s_in.data = (req_we_i || err) ? '0 : rd_word;
  end

  // Read pipeline: always advances, the FIFO absorbs backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= acc;
      dat_pipe[0] <= acc ? s_in : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign p_vld   = vld_pipe[RD_LAT-1];
  assign p_dat   = dat_pipe[RD_LAT-1];
  assign f_empty = (f_cnt == '0);
  // Pipeline output bypasses an empty FIFO when the consumer takes it now.
  assign push    = p_vld && !(f_empty && rsp_ready_i);
  assign pop     = !f_empty && rsp_ready_i;

  // FIFO storage; only read while occupied so no reset needed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= p_dat;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      f_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   f_cnt <= f_cnt + CW'(1);
        2'b01:   f_cnt <= f_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // Credits: everything accepted but not yet consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up     <= 1'b0;
      credit <= '0;
    end else begin
      up <= 1'b1;
      case ({acc, cons})
        2'b10:   credit <= credit + CW'(1);
        2'b01:   credit <= credit - CW'(1);
        default: ;
      endcase
    end
  end

  assign req_ready_o = up && (credit < CW'(FD));
  assign head        = f_empty ? p_dat : fifo_mem[rd_ptr];
  assign rsp_valid_o = !f_empty || p_vld;
  assign rsp_rdata_o = rsp_valid_o ? head.data : '0;
  assign rsp_err_o   = rsp_valid_o && head.err;
endmodule

// File: tb/tb_ram_be_pipe.sv
// Bench for ram_be_pipe: four instances (RD_LAT 1..4, last one ALIGN_CHK=0),
// a transaction-level reference model checked every cycle, a vector table,
// and directed backpressure / streaming / reset sequences.
module tb_ram_be_pipe;
  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we    [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic [3:0]  req_be    [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      ram_be_pipe #(.DATA_W(32), .DEPTH(4096), .ADDR_W(32), .RD_LAT(g + 1),
                    .ALIGN_CHK(g == 3 ? 0 : 1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid[g]), .req_ready_o(req_ready[g]),
        .req_we_i(req_we[g]), .req_addr_i(req_addr[g]),
        .req_wdata_i(req_wdata[g]), .req_be_i(req_be[g]),
        .rsp_valid_o(rsp_valid[g]), .rsp_ready_i(rsp_ready[g]),
        .rsp_rdata_o(rsp_rdata[g]), .rsp_err_o(rsp_err[g])
      );
    end
  endgenerate

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: per instance, a queue of pending responses, each tagged
  // with the cycle it becomes visible, plus a plain word-array memory.
  typedef struct {
    int          t;
    logic        err;
    logic [31:0] d;
  } ent_t;
  ent_t        mq  [NI][$];
  logic [31:0] mm  [NI][4096];
  int          cyc [NI];
  bit          mup [NI];
  logic [31:0] pre [64];

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) begin
          mq[i].delete();
          mup[i] = 0;
          cyc[i] = 0;
        end else begin
          if (mup[i]) begin
            bit ev, er, ac;
            ev = mq[i].size() > 0 && mq[i][0].t <= cyc[i];
            er = mq[i].size() < i + 2;
            ac = req_valid[i] && er;
            if (ev && rsp_ready[i]) void'(mq[i].pop_front());
            cyc[i]++;
            if (ac) begin
              ent_t e;
              logic [31:0] a;
              int wi;
              a = req_addr[i];
              wi = int'((a / 4) % 4096);
              e.err = (a >= 32'h4000) || ((i != 3) && (a % 4 != 0));
              e.d = '0;
              e.t = cyc[i] + i;
              if (!e.err) begin
                if (req_we[i]) begin
                  for (int b = 0; b < 4; b++)
                    if (req_be[i][b]) mm[i][wi][8*b +: 8] = req_wdata[i][8*b +: 8];
                end else e.d = mm[i][wi];
              end
              mq[i].push_back(e);
            end
          end
          mup[i] = 1;
        end
        begin
          bit xv;
          xv = rst_n && mq[i].size() > 0 && mq[i][0].t <= cyc[i];
          check($sformatf("mon%0d_ready", i), 32'(req_ready[i]),
                32'(rst_n && mup[i] && mq[i].size() < i + 2));
          check($sformatf("mon%0d_valid", i), 32'(rsp_valid[i]), 32'(xv));
          if (xv) begin
            check($sformatf("mon%0d_rdata", i), rsp_rdata[i], mq[i][0].d);
            check($sformatf("mon%0d_err", i), 32'(rsp_err[i]), 32'(mq[i][0].err));
          end else if (!rst_n) begin
            check($sformatf("mon%0d_rst_rdata", i), rsp_rdata[i], 32'h0);
            check($sformatf("mon%0d_rst_err", i), 32'(rsp_err[i]), 32'h0);
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NI; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      req_be[i]    = '0;
      rsp_ready[i] = 1'b1;
    end
  endtask

  task automatic one_req(input int inst, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be,
                         input bit eerr, input logic [31:0] ed, input string nm);
    bit got = 0;
    idle_all();
    req_valid[inst] = 1'b1;
    req_we[inst]    = we;
    req_addr[inst]  = addr;
    req_wdata[inst] = wd;
    req_be[inst]    = be;
    tick();
    req_valid[inst] = 1'b0;
    for (int n = 1; n <= 8 && !got; n++) begin
      if (rsp_valid[inst]) begin
        got = 1;
        check({nm, "_lat"}, 32'(n), 32'(inst + 1));
        check({nm, "_rdata"}, rsp_rdata[inst], ed);
        check({nm, "_err"}, 32'(rsp_err[inst]), 32'(eerr));
      end else tick();
    end
    if (!got) check({nm, "_timeout"}, 32'h0, 32'h1);
    tick();
  endtask

  typedef struct {
    int          inst;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          eerr;
    logic [31:0] edata;
    string       nm;
  } vec_t;

  initial begin
    vec_t        vt [15];
    logic [31:0] got [$];
    int          nacc, first, last, drops, stale;
    bit          a, r;
    logic [31:0] rd;

    vt[0]  = '{0, 1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 32'h0,        "wr_10"};
    vt[1]  = '{0, 0, 32'h10,   32'h0,        4'h0, 0, 32'hDEADBEEF, "rd_10"};
    vt[2]  = '{0, 1, 32'h20,   32'hAAAAAAAA, 4'hF, 0, 32'h0,        "wr_20"};
    vt[3]  = '{0, 1, 32'h20,   32'h11223344, 4'h5, 0, 32'h0,        "wr_be5"};
    vt[4]  = '{0, 0, 32'h20,   32'h0,        4'h0, 0, 32'hAA22AA44, "rd_be5"};
    vt[5]  = '{0, 0, 32'h4000, 32'h0,        4'h0, 1, 32'h0,        "rd_oor"};
    vt[6]  = '{0, 1, 32'h12,   32'h55555555, 4'hF, 1, 32'h0,        "wr_mis"};
    vt[7]  = '{0, 0, 32'h10,   32'h0,        4'h0, 0, 32'hDEADBEEF, "rd_after_mis"};
    vt[8]  = '{3, 1, 32'h10,   32'hCAFEF00D, 4'hF, 0, 32'h0,        "na_wr_10"};
    vt[9]  = '{3, 0, 32'h12,   32'h0,        4'h0, 0, 32'hCAFEF00D, "na_rd_12"};
    vt[10] = '{0, 1, 32'h24,   32'h0BADF00D, 4'hF, 0, 32'h0,        "wr_24"};
    vt[11] = '{0, 1, 32'h24,   32'hFFFFFFFF, 4'h0, 0, 32'h0,        "wr_be0"};
    vt[12] = '{0, 0, 32'h24,   32'h0,        4'h0, 0, 32'h0BADF00D, "rd_be0"};
    vt[13] = '{0, 1, 32'h3FFC, 32'h13579BDF, 4'hF, 0, 32'h0,        "wr_top"};
    vt[14] = '{0, 0, 32'h3FFC, 32'h0,        4'h0, 0, 32'h13579BDF, "rd_top"};

    for (int i = 0; i < NI; i++)
      for (int w = 0; w < 4096; w++) mm[i][w] = '0;
    for (int k = 0; k < 64; k++) pre[k] = $urandom;
    idle_all();
    fork monitor(); join_none

    // Reset state
    tick(); tick();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst%0d_ready", i), 32'(req_ready[i]), 32'h0);
      check($sformatf("rst%0d_valid", i), 32'(rsp_valid[i]), 32'h0);
    end
    rst_n = 1'b1;
    check("ready_before_edge", 32'(req_ready[0]), 32'h0);
    tick();
    check("ready_after_edge", 32'(req_ready[0]), 32'h1);

    // Preload words 0..63 of every instance
    for (int k = 0; k < 64; k++) begin
      for (int i = 0; i < NI; i++) begin
        req_valid[i] = 1'b1;
        req_we[i]    = 1'b1;
        req_addr[i]  = 32'(4 * k);
        req_wdata[i] = pre[k];
        req_be[i]    = 4'hF;
      end
      tick();
    end
    idle_all();
    repeat (6) tick();

    for (int k = 0; k < 15; k++)
      one_req(vt[k].inst, vt[k].we, vt[k].addr, vt[k].wdata, vt[k].be,
              vt[k].eerr, vt[k].edata, vt[k].nm);

    // Streaming on RD_LAT=2
    idle_all();
    req_valid[1] = 1'b1;
    nacc = 0; first = -1; last = -1; drops = 0;
    got.delete();
    for (int c = 0; c < 30; c++) begin
      a = req_valid[1] && req_ready[1];
      if (req_valid[1] && !req_ready[1]) drops++;
      if (rsp_valid[1]) begin
        if (first < 0) first = c;
        last = c;
        got.push_back(rsp_rdata[1]);
      end
      tick();
      if (a) begin
        nacc++;
        if (nacc == 16) req_valid[1] = 1'b0;
        else req_addr[1] = 32'(4 * nacc);
      end
    end
    check("stream_drops", 32'(drops), 32'h0);
    check("stream_first", 32'(first), 32'h2);
    check("stream_span", 32'(last - first), 32'd15);
    check("stream_count", 32'(got.size()), 32'd16);
    for (int k = 0; k < got.size() && k < 16; k++)
      check($sformatf("stream_d%0d", k), got[k], pre[k]);

    // Backpressure on RD_LAT=3
    idle_all();
    rsp_ready[2] = 1'b0;
    req_valid[2] = 1'b1;
    nacc = 0;
    got.delete();
    for (int c = 0; c < 40; c++) begin
      if (c == 12) begin
        check("bp_accepts", 32'(nacc), 32'd4);
        check("bp_ready_low", 32'(req_ready[2]), 32'h0);
        check("bp_valid_held", 32'(rsp_valid[2]), 32'h1);
        check("bp_head", rsp_rdata[2], pre[0]);
        rsp_ready[2] = 1'b1;
      end
      a = req_valid[2] && req_ready[2];
      r = rsp_valid[2] && rsp_ready[2];
      rd = rsp_rdata[2];
      tick();
      if (r) got.push_back(rd);
      if (a) begin
        nacc++;
        if (nacc == 5) req_valid[2] = 1'b0;
        else req_addr[2] = 32'(4 * nacc);
      end
    end
    check("bp_total_acc", 32'(nacc), 32'd5);
    check("bp_total_rsp", 32'(got.size()), 32'd5);
    for (int k = 0; k < got.size() && k < 5; k++)
      check($sformatf("bp_d%0d", k), got[k], pre[k]);

    // Reset with reads in flight on RD_LAT=2
    one_req(1, 1, 32'h30, 32'h600DCAFE, 4'hF, 0, 32'h0, "pre_rst_wr");
    idle_all();
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h0;
    tick();
    req_addr[1]  = 32'h4;
    tick();
    req_valid[1] = 1'b0;
    check("inflight_valid", 32'(rsp_valid[1]), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(rsp_valid[1]), 32'h0);
    check("rst_async_ready", 32'(req_ready[1]), 32'h0);
    check("rst_async_rdata", rsp_rdata[1], 32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      for (int i = 0; i < NI; i++) if (rsp_valid[i]) stale++;
    end
    check("rst_stale", 32'(stale), 32'h0);
    one_req(1, 0, 32'h30, 32'h0, 4'h0, 0, 32'h600DCAFE, "rst_rdbk");

    // Randomized traffic, checked by the monitor every cycle
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NI; i++) begin
        req_valid[i] = ($urandom_range(0, 9) < 7);
        req_we[i]    = $urandom_range(0, 1) == 1;
        case ($urandom_range(0, 9))
          0:       req_addr[i] = 32'h4000 + 32'($urandom_range(0, 32'hFFFF));
          1:       req_addr[i] = $urandom | 32'h8000_0000;
          default: req_addr[i] = 32'($urandom_range(0, 255));
        endcase
        req_wdata[i] = $urandom;
        req_be[i]    = 4'($urandom_range(0, 15));
        rsp_ready[i] = ($urandom_range(0, 9) < 6);
      end
      tick();
    end
    idle_all();
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
